// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 keypad column scanner with row synchronizer, per-scan debounce and key strobe.
// Define KEYPAD_REPEAT_EN to auto-repeat key_valid while a key is held.
module keypad_scanner #(
  parameter int unsigned SETTLE_CYCLES  = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_MAX    = DB_W'(DEBOUNCE_SCANS);

  typedef enum logic [2:0] {IDLE, COL0, COL1, COL2, COL3} state_t;

  if (SETTLE_CYCLES < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
    $error("keypad_scanner: parameter out of range");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       col_nxt;
  logic             slot_end_c;
  logic [3:0]       row_s1, row_s2;
  logic [3:0]       pressed_c;
  logic             hit_c;
  logic [1:0]       row_idx_c, col_idx_c;
  logic             acc_valid, cand_valid, prev_valid, eval;
  logic [3:0]       acc_code, cand_code, prev_code;
  logic [DB_W-1:0]  stable, stable_nxt_c;
  logic             same_c, accept_c, new_key_c;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  // Two-flop synchronizer; idle rows read as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      col_n <= 4'b1111;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      col_n <= col_nxt;
    end
  end

  // IDLE lasts one cycle after reset so col_n and the slot counter start aligned.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    slot_end_c = 1'b0;
    if (state == IDLE) begin
      state_nxt = COL0;
      cnt_nxt   = '0;
    end else if (cnt == SLOT_LAST) begin
      slot_end_c = 1'b1;
      cnt_nxt    = '0;
      case (state)
        COL0:    state_nxt = COL1;
        COL1:    state_nxt = COL2;
        COL2:    state_nxt = COL3;
        default: state_nxt = COL0;
      endcase
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    col_nxt   = 4'b1111;
    col_idx_c = 2'd0;
    case (state_nxt)
      COL0:    col_nxt = 4'b1110;
      COL1:    col_nxt = 4'b1101;
      COL2:    col_nxt = 4'b1011;
      COL3:    col_nxt = 4'b0111;
      default: col_nxt = 4'b1111;
    endcase
    case (state)
      COL1:    col_idx_c = 2'd1;
      COL2:    col_idx_c = 2'd2;
      COL3:    col_idx_c = 2'd3;
      default: col_idx_c = 2'd0;
    endcase
  end

  always_comb begin
    pressed_c = ~row_s2;
    hit_c     = |pressed_c;
    if (pressed_c[0])      row_idx_c = 2'd0;
    else if (pressed_c[1]) row_idx_c = 2'd1;
    else if (pressed_c[2]) row_idx_c = 2'd2;
    else                   row_idx_c = 2'd3;
  end

  // First hit in scan order wins; the scan result is handed to debounce after COL3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_valid  <= 1'b0;
      acc_code   <= 4'h0;
      cand_valid <= 1'b0;
      cand_code  <= 4'h0;
      eval       <= 1'b0;
    end else begin
      eval <= 1'b0;
      if (slot_end_c) begin
        if (state == COL3) begin
          eval      <= 1'b1;
          acc_valid <= 1'b0;
          acc_code  <= 4'h0;
          if (acc_valid) begin
            cand_valid <= 1'b1;
            cand_code  <= acc_code;
          end else if (hit_c) begin
            cand_valid <= 1'b1;
            cand_code  <= key_map(row_idx_c, col_idx_c);
          end else begin
            cand_valid <= 1'b0;
            cand_code  <= 4'h0;
          end
        end else if (hit_c && !acc_valid) begin
          acc_valid <= 1'b1;
          acc_code  <= key_map(row_idx_c, col_idx_c);
        end
      end
    end
  end

  always_comb begin
    same_c       = ({cand_valid, cand_code} == {prev_valid, prev_code});
    stable_nxt_c = same_c ? ((stable == DB_MAX) ? DB_MAX : stable + DB_W'(1)) : DB_W'(1);
    accept_c     = (stable_nxt_c == DB_MAX) && !(same_c && (stable == DB_MAX));
    new_key_c    = cand_valid && (!key_down || (cand_code != key_code));
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
  logic [REP_W-1:0] rep_cnt;
  logic             hold_c;
  assign hold_c = same_c && (stable == DB_MAX) && cand_valid && key_down && (cand_code == key_code);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_code  <= 4'h0;
      stable     <= '0;
      key_code   <= 4'h0;
      key_down   <= 1'b0;
      key_valid  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (eval) begin
        prev_valid <= cand_valid;
        prev_code  <= cand_code;
        stable     <= stable_nxt_c;
        if (accept_c) begin
          if (new_key_c) begin
            key_code  <= cand_code;
            key_down  <= 1'b1;
            key_valid <= 1'b1;
          end else if (!cand_valid) begin
            key_down <= 1'b0;
          end
        end
`ifdef KEYPAD_REPEAT_EN
        if (!hold_c) begin
          rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
          rep_cnt   <= '0;
          key_valid <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + REP_W'(1);
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model plus scan-level reference model for keypad_scanner.
module tb_keypad_scanner;
  localparam int unsigned S = 4;
  localparam int unsigned D = 3;
  localparam int unsigned R = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row_n, col_n, key_code;
  logic        key_valid, key_down;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held

  int tests = 0;
  int fails = 0;
  int hist[$];
  int m_code = 0;
  bit m_down = 1'b0;
  int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

  keypad_scanner #(.SETTLE_CYCLES(S), .DEBOUNCE_SCANS(D), .REPEAT_SCANS(R)) dut (
    .clk(clk), .rst_n(rst_n), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Passive keypad: a row is pulled low by any held key whose column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int cand_of(input logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[r*4 + c]) return keymap[r*4 + c];
    return -1;
  endfunction

  // Acceptance happens when the current candidate's run length reaches exactly D.
  function automatic int model_scan(input logic [15:0] k);
    int cand, run, strobe;
    cand = cand_of(k);
    hist.push_back(cand);
    run = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == cand) run++;
      else break;
    end
    strobe = 0;
    if (run == D) begin
      if (cand < 0) m_down = 1'b0;
      else if (!m_down || cand != m_code) begin
        m_code = cand;
        m_down = 1'b1;
        strobe = 1;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    else if (run > D && cand >= 0 && m_down && cand == m_code && ((run - D) % R) == 0) strobe = 1;
`endif
    return strobe;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_code = 0;
    m_down = 1'b0;
  endtask

  // Entered at the negedge of the second cycle of a COL0 slot; leaves at the same point one scan later.
  task automatic run_scan(input logic [15:0] k);
    int exp_strobe, strobes, pos;
    keys = k;
    exp_strobe = model_scan(k);
    strobes = 0;
    for (int i = 1; i <= 4 * S; i++) begin
      @(negedge clk);
      pos = (1 + i) % (4 * S);
      check("col_n", {28'd0, col_n}, {28'd0, 4'hF ^ (4'h1 << (pos / S))});
      if (key_valid === 1'b1) strobes++;
    end
    check("strobes", strobes, exp_strobe);
    check("key_code", {28'd0, key_code}, m_code);
    check("key_down", {31'd0, key_down}, {31'd0, m_down});
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) run_scan(k);
  endtask

  task automatic align();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (col_n !== 4'b1110 && n < 20);
    check("align", {28'd0, col_n}, 32'hE);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_n"},     {28'd0, col_n}, 32'hF);
    check({tag, "_key_code"},  {28'd0, key_code}, 32'h0);
    check({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
    check({tag, "_key_down"},  {31'd0, key_down}, 32'h0);
  endtask

  initial begin
    logic [15:0] m;
    int sel, n;
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    logic [15:0] m;
    int sel, n;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    model_reset();
    align();

    hold(16'h0000, 2);                  // idle scans, column sequence
    hold(16'h0004, 4);                  // '3' accepted after D scans
    hold(16'h0000, 3);                  // release
    hold(16'h0020, 2);                  // '5' glitch shorter than D
    hold(16'h0000, 3);
    hold(16'h0100, 4);                  // '7'
    hold(16'h8000, 4);                  // direct change to 'D'
    hold(16'h0000, 4);                  // release, key_code stays D
    hold(16'h0009, 4);                  // '1' + 'A': column 0 wins

    for (int g = 0; g < 10; g++) begin
      sel = $urandom_range(0, 3);
      m = '0;
      if (sel != 0) m[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) m[$urandom_range(0, 15)] = 1'b1;
      n = $urandom_range(1, 5);
      hold(m, n);
    end

    hold(16'h0000, 3);
    hold(16'h0200, 7);                  // '8' held: repeat strobes when enabled

    repeat (5) @(negedge clk);          // abort mid-scan
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    keys = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("inreset");
    rst_n = 1'b1;
    model_reset();
    align();
    hold(16'h0000, 1);
    hold(16'h4000, 4);                  // 'E' after restart

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
